// File: rtl/jt03_mixn_if.sv
// jt03_mixn_if: bus between a controller/board and the jt03_mixn mixer.
// The clock and reset are kept as plain ports on the mixer, not in this interface.
//
// Signals:
//   cen       clock enable for the mixer
//   sample    new-sample strobe
//   ch_in     NCH*W packed source samples; source k is at [k*W+:W]
//   ch_uns    per-source flag: the source is unsigned (offset binary)
//   gain      NCH*GW packed per-source gains, unsigned Q(GW-4).4
//   peak_clr  clears the peak detector
//   snd       signed mixed sample
//   snd_valid one-clock pulse when snd updates
//   busy      a MAC sequence is in progress
//   clip      the last sample saturated
//   overrun   sticky flag: a strobe arrived while the mixer was busy
//   peak      peak |snd| since the last clear
//
// Modports:
//   master    the driving side (board logic, testbench)
//   slave     the mixer
interface jt03_mixn_if #(
    parameter int NCH = 4,
    parameter int W   = 16,
    parameter int GW  = 8,
    parameter int OW  = 16
);
    logic                cen;
    logic                sample;
    logic [NCH*W-1:0]    ch_in;
    logic [NCH-1:0]      ch_uns;
    logic [NCH*GW-1:0]   gain;
    logic                peak_clr;
    logic signed [OW-1:0] snd;
    logic                snd_valid;
    logic                busy;
    logic                clip;
    logic                overrun;
    logic [OW-1:0]       peak;

    modport master (
        output cen, sample, ch_in, ch_uns, gain, peak_clr,
        input  snd, snd_valid, busy, clip, overrun, peak
    );

    modport slave (
        input  cen, sample, ch_in, ch_uns, gain, peak_clr,
        output snd, snd_valid, busy, clip, overrun, peak
    );
endinterface

// File: rtl/jt03_mixn.sv
// jt03_mixn: N-source sample mixer.
//
// Operation:
//   On each sample strobe the mixer captures every source and its gain.
//   It then multiplies each source by its gain and accumulates the products
//   with one MAC, one source per enabled cycle.
//   The sum is scaled by 1/16, saturated to OW bits, and output as a single
//   mixed sample.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    jt03_mixn_if.slave (cen, sample, ch_in, ch_uns, gain, peak_clr in;
//          snd, snd_valid, busy, clip, overrun, peak out)
//
// Optional feature:
//   JT03_MIXN_PEAK_EN  when defined, builds the peak |snd| detector.
//                      When not defined, peak is tied to 0.
module jt03_mixn #(
    parameter int NCH = 4,
    parameter int W   = 16,
    parameter int GW  = 8,
    parameter int OW  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    jt03_mixn_if.slave   bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW = W + GW + $clog2(NCH);
    localparam int PW = W + GW + 1;
    localparam int RW = AW - 4;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         src_q  [NCH];
    logic [GW-1:0]        gain_q [NCH];
    logic [NCH-1:0]       uns_q;
    logic signed [AW-1:0] acc_q;
    logic [IW-1:0]        idx_q;
    logic signed [OW-1:0] snd_q, snd_d;
    logic                 valid_q, clip_q, clip_d, overrun_q;

    logic                 accept, mac_en, fire, last_idx;
    logic [W-1:0]         src_sel;
    logic [GW-1:0]        gain_sel;
    logic signed [PW-1:0] prod;
    logic signed [RW-1:0] r;
    logic [RW-OW:0]       r_hi;
    logic                 ovf;

    // Shadow copies of the sources, so the inputs may change during MAC.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    src_q[gi]  <= '0;
                    gain_q[gi] <= '0;
                    uns_q[gi]  <= 1'b0;
                end else if (accept) begin
                    src_q[gi]  <= bus.ch_in[gi*W +: W];
                    gain_q[gi] <= bus.gain[gi*GW +: GW];
                    uns_q[gi]  <= bus.ch_uns[gi];
                end
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cen && bus.sample) state_d = MAC;
            MAC:     if (bus.cen && last_idx)   state_d = OUT;
            OUT:     if (bus.cen)               state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decoded controls
    always_comb begin
        accept = bus.cen && bus.sample && (state_q == IDLE);
        mac_en = bus.cen && (state_q == MAC);
        fire   = bus.cen && (state_q == OUT);
    end

    assign last_idx = (idx_q == IW'(NCH - 1));

    // Offset-binary sources are re-centred by flipping the MSB.
    // The gain gets a zero bit on top so the multiply stays signed.
    assign src_sel  = {src_q[idx_q][W-1] ^ uns_q[idx_q], src_q[idx_q][W-2:0]};
    assign gain_sel = gain_q[idx_q];
    assign prod     = $signed(src_sel) * $signed({1'b0, gain_sel});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            idx_q <= '0;
        end else if (accept) begin
            acc_q <= '0;
            idx_q <= '0;
        end else if (mac_en) begin
            // The product fits in W+GW signed bits, so this cast is lossless.
            acc_q <= acc_q + AW'(prod);
            idx_q <= idx_q + 1'b1;
        end
    end

    // Drop the 4 fractional gain bits. The result saturates when the bits
    // above the OW-bit sign bit are not all copies of that sign bit.
    assign r    = acc_q[AW-1:4];
    assign r_hi = r[RW-1:OW-1];
    assign ovf  = !((&r_hi) || !(|r_hi));

    always_comb begin
        clip_d = ovf;
        snd_d  = r[OW-1:0];
        if (ovf) snd_d = r[RW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snd_q     <= '0;
            clip_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= fire;
            if (fire) begin
                snd_q  <= snd_d;
                clip_q <= clip_d;
            end
            if (bus.cen && bus.sample && (state_q != IDLE)) overrun_q <= 1'b1;
        end
    end

    assign bus.snd       = snd_q;
    assign bus.snd_valid = valid_q;
    assign bus.clip      = clip_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != IDLE);

`ifdef JT03_MIXN_PEAK_EN
    logic [OW-1:0] peak_q, abs_d;

    // The most negative value has no positive twin, so its magnitude is clamped.
    always_comb begin
        abs_d = snd_d;
        if (snd_d[OW-1]) begin
            if (snd_d == {1'b1, {(OW-1){1'b0}}}) abs_d = {1'b0, {(OW-1){1'b1}}};
            else                                 abs_d = OW'(-snd_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (bus.cen) begin
            if (bus.peak_clr)                  peak_q <= fire ? abs_d : '0;
            else if (fire && (abs_d > peak_q)) peak_q <= abs_d;
        end
    end

    assign bus.peak = peak_q;
`else
    assign bus.peak = '0;
`endif
endmodule

// File: tb/tb_jt03_mixn.sv
module tb_jt03_mixn;
    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int GW  = 8;
    localparam int OW  = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   lat;
    int   nval;

    jt03_mixn_if #(.NCH(NCH), .W(W), .GW(GW), .OW(OW)) bus ();

    jt03_mixn #(.NCH(NCH), .W(W), .GW(GW), .OW(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-14s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_src(input int a, input int b, input int c, input int d,
                           input int ga, input int gb, input int gc, input int gd,
                           input logic [3:0] uns);
        bus.ch_in  = {16'(d), 16'(c), 16'(b), 16'(a)};
        bus.gain   = {8'(gd), 8'(gc), 8'(gb), 8'(ga)};
        bus.ch_uns = uns;
    endtask

    // Strobe one sample (held until a cen edge takes it), then count the
    // enabled edges until snd_valid. lat is -1 if the budget expires.
    task automatic mix(input bit slow, output int lat_o);
        int  k;
        bit  taken;
        k = 0;
        taken = 1'b0;
        lat_o = 0;
        bus.sample = 1'b1;
        while (!taken && k < 100) begin
            bus.cen = slow ? (k % 3 == 0) : 1'b1;
            step();
            k++;
            if (bus.cen) taken = 1'b1;
        end
        bus.sample = 1'b0;
        while (k < 200) begin
            bus.cen = slow ? (k % 3 == 0) : 1'b1;
            step();
            k++;
            if (bus.cen) lat_o++;
            if (bus.snd_valid) break;
        end
        if (!bus.snd_valid) lat_o = -1;
        bus.cen = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.cen = 1'b0;
        bus.sample = 1'b0;
        bus.peak_clr = 1'b0;
        set_src(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        #1;
        chk("rst_snd", int'(bus.snd), 0);
        chk("rst_valid", int'(bus.snd_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_clip", int'(bus.clip), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        chk("rst_peak", int'(bus.peak), 0);
        step();
        step();
        rst_n = 1'b1;
        bus.cen = 1'b1;
        step();

        // Basic mix at unity gain.
        set_src(1000, -200, 300, 0, 16, 16, 16, 16, 4'b0000);
        mix(1'b0, lat);
        chk("t1_lat", lat, 5);
        chk("t1_snd", int'($signed(bus.snd)), 1100);
        chk("t1_clip", int'(bus.clip), 0);
        chk("t1_busy", int'(bus.busy), 0);
        step();
        chk("t1_valid_1clk", int'(bus.snd_valid), 0);
        chk("t1_hold", int'($signed(bus.snd)), 1100);

        // Gain 1.5 on a negative source.
        set_src(-1000, 5, 5, 5, 24, 0, 0, 0, 4'b0000);
        mix(1'b0, lat);
        chk("g15_snd", int'($signed(bus.snd)), -1500);

        // The arithmetic shift rounds toward minus infinity.
        set_src(-1, 0, 0, 0, 1, 0, 0, 0, 4'b0000);
        mix(1'b0, lat);
        chk("floor_neg", int'($signed(bus.snd)), -1);
        set_src(15, 0, 0, 0, 1, 0, 0, 0, 4'b0000);
        mix(1'b0, lat);
        chk("floor_pos", int'($signed(bus.snd)), 0);

        // Unsigned source re-centring.
        set_src(16'h8000, 1234, 1234, 1234, 32, 0, 0, 0, 4'b0001);
        mix(1'b0, lat);
        chk("uns_mid", int'($signed(bus.snd)), 0);
        chk("uns_mid_clip", int'(bus.clip), 0);
        set_src(16'hC000, 1234, 1234, 1234, 32, 0, 0, 0, 4'b0001);
        mix(1'b0, lat);
        chk("uns_sat", int'($signed(bus.snd)), 32767);
        chk("uns_sat_clip", int'(bus.clip), 1);

        // Saturation at both rails.
        set_src(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 255, 255, 255, 255, 4'b0000);
        mix(1'b0, lat);
        chk("sat_max", int'($signed(bus.snd)), 32767);
        chk("sat_max_clip", int'(bus.clip), 1);
        set_src(16'h8000, 16'h8000, 16'h8000, 16'h8000, 255, 255, 255, 255, 4'b0000);
        mix(1'b0, lat);
        chk("sat_min", int'($signed(bus.snd)), -32768);
        chk("sat_min_clip", int'(bus.clip), 1);

        // Clock enable active one cycle in three gives the same result.
        set_src(1000, -200, 300, 0, 16, 16, 16, 16, 4'b0000);
        mix(1'b1, lat);
        chk("slow_lat", lat, 5);
        chk("slow_snd", int'($signed(bus.snd)), 1100);
        chk("slow_clip", int'(bus.clip), 0);
        chk("maxrate_ovr", int'(bus.overrun), 0);

`ifdef JT03_MIXN_PEAK_EN
        bus.peak_clr = 1'b1;
        step();
        bus.peak_clr = 1'b0;
        chk("peak_clr", int'(bus.peak), 0);
        set_src(500, 0, 0, 0, 16, 0, 0, 0, 4'b0000);
        mix(1'b0, lat);
        set_src(-3000, 0, 0, 0, 16, 0, 0, 0, 4'b0000);
        mix(1'b0, lat);
        set_src(200, 0, 0, 0, 16, 0, 0, 0, 4'b0000);
        mix(1'b0, lat);
        chk("peak_3000", int'(bus.peak), 3000);
        bus.peak_clr = 1'b1;
        set_src(100, 0, 0, 0, 16, 0, 0, 0, 4'b0000);
        mix(1'b0, lat);
        bus.peak_clr = 1'b0;
        chk("peak_clr_val", int'(bus.peak), 100);
`else
        chk("peak_tied", int'(bus.peak), 0);
`endif

        // A second strobe two cycles after the first is an overrun.
        set_src(1000, -200, 300, 0, 16, 16, 16, 16, 4'b0000);
        bus.sample = 1'b1;
        step();
        bus.sample = 1'b0;
        set_src(7000, 7000, 7000, 7000, 16, 16, 16, 16, 4'b0000);
        step();
        bus.sample = 1'b1;
        step();
        bus.sample = 1'b0;
        chk("ovr_set", int'(bus.overrun), 1);
        lat = 0;
        while (lat < 20 && !bus.snd_valid) begin
            step();
            lat++;
        end
        chk("ovr_lat", lat, 3);
        chk("ovr_snd", int'($signed(bus.snd)), 1100);
        nval = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.snd_valid) nval++;
        end
        chk("ovr_no_2nd", nval, 0);
        chk("ovr_sticky", int'(bus.overrun), 1);

        // Asynchronous reset in the middle of MAC.
        bus.sample = 1'b1;
        step();
        bus.sample = 1'b0;
        step();
        step();
        chk("mid_busy", int'(bus.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_snd", int'($signed(bus.snd)), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_ovr", int'(bus.overrun), 0);
        step();
        rst_n = 1'b1;
        step();

        // A strobe on the output edge counts as busy.
        set_src(40, 0, 0, 0, 16, 0, 0, 0, 4'b0000);
        bus.sample = 1'b1;
        step();
        bus.sample = 1'b0;
        for (int i = 0; i < 4; i++) step();
        bus.sample = 1'b1;
        step();
        bus.sample = 1'b0;
        chk("outedge_valid", int'(bus.snd_valid), 1);
        chk("outedge_snd", int'($signed(bus.snd)), 40);
        chk("outedge_ovr", int'(bus.overrun), 1);
        nval = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.snd_valid) nval++;
        end
        chk("outedge_ign", nval, 0);
        chk("outedge_idle", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
